// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: slice width and FSM encoding.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit add/subtract slice; c3 is the carry into bit 3 for overflow detection.
module addsub_nibble
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                mode,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] bx;
  logic [NIBBLE_W:0]   full;
  logic [NIBBLE_W-1:0] low;

  // Subtraction is a + ~b + 1, the +1 arriving as the initial carry.
  assign bx   = b ^ {NIBBLE_W{mode}};
  assign full = {1'b0, a} + {1'b0, bx} + {{NIBBLE_W{1'b0}}, cin};
  assign low  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, bx[NIBBLE_W-2:0]} + {{(NIBBLE_W-1){1'b0}}, cin};

  assign sum  = full[NIBBLE_W-1:0];
  assign cout = full[NIBBLE_W];
  assign c3   = low[NIBBLE_W-1];

endmodule

// File: rtl/serial_addsub_16bit.sv
// Nibble-serial adder/subtractor: one 4-bit slice per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining ADDSUB_OVF_EN.
module serial_addsub_16bit
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        cout,
  output logic                        busy
`ifdef ADDSUB_OVF_EN
  ,
  output logic                        ovf
`endif
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state, state_nxt;
  logic [W-1:0]        a_q, b_q, result_q;
  logic                mode_q, carry_q, cout_q;
  logic [IDX_W-1:0]    idx_q;
  logic                accept, last_nib;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
`ifdef ADDSUB_OVF_EN
  logic                nib_c3;
  logic                ovf_q;
`else
  logic                unused_c3;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_nib  = (state == RUN) && (idx_q == LAST_IDX);
  assign result    = result_q;
  assign cout      = cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_nib)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Operands are captured once so input changes during RUN cannot leak in.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

  addsub_nibble u_nibble (
    .a    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .mode (mode_q),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout),
`ifdef ADDSUB_OVF_EN
    .c3   (nib_c3)
`else
    .c3   (unused_c3)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= mode;
    end else if (state == RUN) begin
      result_q[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_sum;
      carry_q <= nib_cout;
      idx_q   <= idx_q + 1'b1;
      if (last_nib) cout_q <= nib_cout;
    end
  end

`ifdef ADDSUB_OVF_EN
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_q <= 1'b0;
    else if (last_nib) ovf_q <= nib_c3 ^ nib_cout;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_16bit.sv
// Scoreboard bench for serial_addsub_16bit; define ADDSUB_OVF_EN to also check ovf.
module tb_serial_addsub_16bit;

  localparam int NIBBLES = 4;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        busy;
`ifdef ADDSUB_OVF_EN
  logic        ovf;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_addsub_16bit #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(result), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.co));
`ifdef ADDSUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  // Waits for in_ready, issues one operation, scrambles inputs, checks latency.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tm,
                      input logic [15:0] eres, input logic eco, input logic eov);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    e.res = eres; e.co = eco; e.ov = eov;
    sb.push_back(e);
    a = ta; b = tb; mode = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; mode = ~tm;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(NIBBLES));
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    send(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: hold DONE for 5 cycles while poking in_valid.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 16'h0F0F; b = 16'h0F0F;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'h0000_BCDE);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_valid", 32'(out_valid), 32'd0);
    chk("bp_released_in_ready", 32'(in_ready), 32'd1);
    chk("bp_result_retained", 32'(result), 32'h0000_BCDE);
    chk("bp_queue_drained", 32'(sb.size()), 32'd0);

    // Reset after two nibbles of a run.
    a = 16'hAAAA; b = 16'h1111; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_result", 32'(result), 32'd0);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    end
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub_16bit.md
SERIAL_ADDSUB_16BIT -- requirements
Module: serial_addsub_16bit

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: in_valid  input  1  operand set offered.
REQ-006 SHALL have port: in_ready  output  1  block accepts operands.
REQ-007 SHALL have port: a  input  W  first operand.
REQ-008 SHALL have port: b  input  W  second operand.
REQ-009 SHALL have port: mode  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port: result  output  W  sum/difference modulo 2^W.
REQ-013 SHALL have port: cout  output  1  final carry (subtract: 1 = no borrow).
REQ-014 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL assert in_ready only in IDLE; an operand is accepted on an edge where in_valid & in_ready are both high.
REQ-017 On acceptance, SHALL register a, b, mode, clear the nibble index, set the carry register to mode, and enter RUN.
REQ-018 In RUN, on edge i+1 (i = 0..NIBBLES-1), SHALL compute nibble i as a[i] + (b[i] XOR {4{mode}}) + carry, store 4-bit sum into result[4i+3:4i], and store carry-out into the carry register.
REQ-019 After the edge processing nibble NIBBLES-1, SHALL enter DONE; out_valid SHALL be high exactly NIBBLES cycles after the accepting edge.
REQ-020 In DONE, SHALL hold out_valid, result and cout stable until out_ready is high, then return to IDLE on that edge.
REQ-021 out_valid and out_ready high in the same cycle as out_valid first rises SHALL complete the transfer on that edge; in_ready SHALL rise only on the following cycle (no same-cycle re-accept).
REQ-022 in_valid while busy SHALL be ignored; operand inputs changing during RUN SHALL not affect the result.
REQ-023 result and cout SHALL retain the last completed value while in IDLE.

Reset
REQ-024 rst high SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, result=0, cout=0, carry and index registers=0.
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the operation; no partial result SHALL be presented after release.

Configuration
REQ-026 With ADDSUB_OVF_EN defined, SHALL add output port ovf (1 bit) = carry into MSB XOR carry out of MSB, valid with out_valid, reset to 0.
REQ-027 Without ADDSUB_OVF_EN, SHALL have no ovf port and no related logic; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package addsub_pkg SHALL hold NIBBLE_W=4 and the state encoding (IDLE, RUN, DONE).
REQ-029 SHALL instantiate one sub-module addsub_nibble (4-bit a, b, mode, cin -> sum, cout, c3 for carry into bit 3), combinational.

Verification
REQ-030 Add: a=0x1234, b=0x0FFF, mode=0 -> result=0x2233, cout=0, out_valid 4 cycles after accept.
REQ-031 Add wrap: a=0xFFFF, b=0x0001, mode=0 -> result=0x0000, cout=1; with ADDSUB_OVF_EN, ovf=0.
REQ-032 Subtract: a=0x0005, b=0x0003, mode=1 -> result=0x0002, cout=1; a=0x0003, b=0x0005, mode=1 -> result=0xFFFE, cout=0.
REQ-033 Overflow (ADDSUB_OVF_EN): a=0x7FFF, b=0x0001, mode=0 -> result=0x8000, ovf=1.
REQ-034 Backpressure: out_ready held low 5 cycles in DONE -> out_valid, result stable, in_ready=0, in_valid pulses ignored; transfer on first out_ready.
REQ-035 Reset mid-RUN after 2 nibbles -> outputs zero immediately, IDLE after release, next operation 0x0001+0x0001 -> 0x0002.
